semi_graphics_serializer: RTL and testbench

//  Parametrised semigraphics pixel engine for the VDG path: accepts character bytes from the video

---
 rtl/semi_pkg.sv | 18 +
 rtl/semi_pattern_decode.sv | 57 +++++
 rtl/semi_graphics_serializer.sv | 133 +++++++++++++
 tb/tb_semi_graphics_serializer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/semi_pkg.sv
// Shared types and constants for the semigraphics pixel engine.
package semi_pkg;

  typedef enum logic [1:0] {
    MODE_SG4  = 2'b00,
    MODE_SG6  = 2'b01,
    MODE_SG8  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  localparam int SG4_BANDS = 2;
  localparam int SG6_BANDS = 3;
  localparam int SG8_BANDS = 4;

  // Width of the raw colour field before the +1 offset is applied.
  localparam int BASE_COLOUR_BITS = 3;

endpackage

// File: rtl/semi_pattern_decode.sv
// Combinational block decode: character byte, row, mode and colour set to one
// scanline pixel pattern plus the foreground colour index.
module semi_pattern_decode
  import semi_pkg::*;
#(
  parameter int CHAR_WIDTH    = 8,
  parameter int ROWS_PER_CHAR = 12,
  parameter int COLOUR_BITS   = 4,
  parameter int ROW_W         = $clog2(ROWS_PER_CHAR)
) (
  input  logic [7:0]             data,
  input  logic [ROW_W-1:0]       row,
  input  logic [1:0]             mode,
  input  logic                   css,
  output logic [CHAR_WIDTH-1:0]  pattern,
  output logic [COLOUR_BITS-1:0] colour
);

  localparam int HALF = CHAR_WIDTH / 2;
  localparam logic [CHAR_WIDTH-1:0] LEFT_HALF  = {{HALF{1'b1}}, {HALF{1'b0}}};
  localparam logic [CHAR_WIDTH-1:0] RIGHT_HALF = {{HALF{1'b0}}, {HALF{1'b1}}};

  // Band edges are constants, so band selection is a couple of compares.
  localparam logic [ROW_W-1:0] SG4_EDGE  = ROW_W'(ROWS_PER_CHAR / SG4_BANDS);
  localparam logic [ROW_W-1:0] SG6_EDGE1 = ROW_W'(ROWS_PER_CHAR / SG6_BANDS);
  localparam logic [ROW_W-1:0] SG6_EDGE2 = ROW_W'(2 * ROWS_PER_CHAR / SG6_BANDS);

  logic [1:0]                  pair;
  logic [BASE_COLOUR_BITS-1:0] base_colour;
  logic                        blank;

  always_comb begin
    pair        = 2'b00;
    base_colour = '0;
    blank       = 1'b0;
    case (mode_e'(mode))
      MODE_SG4: begin
        pair        = (row < SG4_EDGE) ? data[1:0] : data[3:2];
        base_colour = data[6:4];
      end
      MODE_SG6: begin
        if (row < SG6_EDGE1)      pair = data[1:0];
        else if (row < SG6_EDGE2) pair = data[3:2];
        else                      pair = data[5:4];
        base_colour = {css, data[7:6]};
      end
      MODE_SG8: begin
        pair        = data[1:0];
        base_colour = data[6:4];
      end
      default: blank = 1'b1;
    endcase
    pattern = (pair[0] ? LEFT_HALF : '0) | (pair[1] ? RIGHT_HALF : '0);
    colour  = blank ? '0 : COLOUR_BITS'(base_colour) + COLOUR_BITS'(1);
  end

endmodule

// File: rtl/semi_graphics_serializer.sv
// Semigraphics pixel engine: one-entry byte hold register, per-scanline block
// decode and a pixel shifter advanced by the dot-clock enable.
module semi_graphics_serializer
  import semi_pkg::*;
#(
  parameter int CHAR_WIDTH    = 8,
  parameter int ROWS_PER_CHAR = 12,
  parameter int COLOUR_BITS   = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [1:0]                       mode,
  input  logic                             css,
  input  logic                             display_en,
  input  logic                             frame_start,
  input  logic                             line_start,
  input  logic                             pixel_en,
  input  logic [7:0]                       data_in,
  input  logic                             data_valid,
  output logic                             data_ready,
  output logic                             pixel_out,
  output logic [COLOUR_BITS-1:0]           colour_out,
  output logic [$clog2(ROWS_PER_CHAR)-1:0] row_out,
  output logic                             underflow
);

  localparam int ROW_W = $clog2(ROWS_PER_CHAR);
  localparam int CNT_W = $clog2(CHAR_WIDTH);

  // Handshake: a byte transfers on any edge where data_valid && data_ready;
  // data_ready depends only on the hold register, never on this cycle's consume.
  logic [7:0]             hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [CNT_W-1:0]       pix_cnt_q, pix_cnt_d;
  logic [CHAR_WIDTH-1:0]  shifter_q, shifter_d;
  logic                   pixel_q, pixel_d;
  logic [COLOUR_BITS-1:0] colour_q, colour_d;
  logic                   underflow_q, underflow_d;

  logic [CHAR_WIDTH-1:0]  dec_pattern;
  logic [COLOUR_BITS-1:0] dec_colour;

  semi_pattern_decode #(
    .CHAR_WIDTH    (CHAR_WIDTH),
    .ROWS_PER_CHAR (ROWS_PER_CHAR),
    .COLOUR_BITS   (COLOUR_BITS),
    .ROW_W         (ROW_W)
  ) u_decode (
    .data    (hold_q),
    .row     (row_q),
    .mode    (mode),
    .css     (css),
    .pattern (dec_pattern),
    .colour  (dec_colour)
  );

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    row_d       = row_q;
    pix_cnt_d   = pix_cnt_q;
    shifter_d   = shifter_q;
    pixel_d     = pixel_q;
    colour_d    = colour_q;
    underflow_d = 1'b0;

    if (frame_start) begin
      row_d     = '0;
      pix_cnt_d = '0;
    end else if (line_start) begin
      row_d     = (row_q == ROW_W'(ROWS_PER_CHAR - 1)) ? '0 : row_q + ROW_W'(1);
      pix_cnt_d = '0;
    end else if (pixel_en && display_en) begin
      if (pix_cnt_q == '0) begin
        if (hold_full_q) begin
          pixel_d     = dec_pattern[CHAR_WIDTH-1];
          shifter_d   = dec_pattern << 1;
          colour_d    = dec_colour;
          hold_full_d = 1'b0;
        end else begin
          pixel_d     = 1'b0;
          colour_d    = '0;
          shifter_d   = '0;
          underflow_d = 1'b1;
        end
      end else begin
        pixel_d   = shifter_q[CHAR_WIDTH-1];
        shifter_d = shifter_q << 1;
      end
      pix_cnt_d = (pix_cnt_q == CNT_W'(CHAR_WIDTH - 1)) ? '0 : pix_cnt_q + CNT_W'(1);
    end else if (pixel_en) begin
      pixel_d   = 1'b0;
      colour_d  = '0;
      pix_cnt_d = '0;
    end

    // Load and consume are exclusive: consume needs a full hold, load an empty one.
    if (data_valid && !hold_full_q) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      row_q       <= '0;
      pix_cnt_q   <= '0;
      shifter_q   <= '0;
      pixel_q     <= 1'b0;
      colour_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      row_q       <= row_d;
      pix_cnt_q   <= pix_cnt_d;
      shifter_q   <= shifter_d;
      pixel_q     <= pixel_d;
      colour_q    <= colour_d;
      underflow_q <= underflow_d;
    end
  end

  assign data_ready = ~hold_full_q;
  assign pixel_out  = pixel_q;
  assign colour_out = colour_q;
  assign row_out    = row_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_semi_graphics_serializer.sv
// Bench for semi_graphics_serializer: directed scenarios plus randomized traffic
// checked against a per-character pixel-array reference model.
module tb_semi_graphics_serializer;

  localparam int CW    = 8;
  localparam int R     = 12;
  localparam int CB    = 4;
  localparam int ROW_W = $clog2(R);

  logic             clk = 1'b0;
  logic             reset, css, display_en, frame_start, line_start, pixel_en, data_valid;
  logic [1:0]       mode;
  logic [7:0]       data_in;
  logic             data_ready, pixel_out, underflow;
  logic [CB-1:0]    colour_out;
  logic [ROW_W-1:0] row_out;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: current character as a pixel array indexed by position.
  int          m_row = 0;
  int          m_pos = 0;
  bit          m_full = 0;
  logic [7:0]  m_byte = '0;
  logic [CW-1:0] m_cur = '0;
  logic        m_pix = 0;
  logic [CB-1:0] m_col = '0;
  logic        m_under = 0;

  semi_graphics_serializer #(
    .CHAR_WIDTH    (CW),
    .ROWS_PER_CHAR (R),
    .COLOUR_BITS   (CB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .css         (css),
    .display_en  (display_en),
    .frame_start (frame_start),
    .line_start  (line_start),
    .pixel_en    (pixel_en),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .pixel_out   (pixel_out),
    .colour_out  (colour_out),
    .row_out     (row_out),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  // Pixel x (0 = leftmost) of a scanline: band from integer row division, half from x.
  function automatic logic [CW-1:0] ref_pattern(logic [7:0] d, int row, logic [1:0] md);
    logic [CW-1:0] p;
    int nb;
    int band;
    int half;
    p = '0;
    case (md)
      2'd0: nb = 2;
      2'd1: nb = 3;
      2'd2: nb = 4;
      default: nb = 0;
    endcase
    if (nb != 0) begin
      band = (md == 2'd2) ? 0 : (row * nb) / R;
      for (int x = 0; x < CW; x++) begin
        half = (x >= CW / 2) ? 1 : 0;
        p[CW-1-x] = d[2*band+half];
      end
    end
    return p;
  endfunction

  function automatic logic [CB-1:0] ref_colour(logic [7:0] d, logic [1:0] md, logic c);
    int v;
    case (md)
      2'd0, 2'd2: v = int'(d[6:4]) + 1;
      2'd1:       v = int'({c, d[7:6]}) + 1;
      default:    v = 0;
    endcase
    return CB'(v);
  endfunction

  // Advance the model with the inputs the DUT is about to sample, then clock.
  task automatic step();
    bit take;
    take    = data_valid && !m_full;
    m_under = 0;
    if (reset) begin
      m_full = 0; m_row = 0; m_pos = 0; m_pix = 0; m_col = '0; m_cur = '0;
    end else begin
      if (frame_start) begin
        m_row = 0; m_pos = 0;
      end else if (line_start) begin
        m_row = (m_row + 1) % R; m_pos = 0;
      end else if (pixel_en && display_en) begin
        if (m_pos == 0) begin
          if (m_full) begin
            m_cur  = ref_pattern(m_byte, m_row, mode);
            m_col  = ref_colour(m_byte, mode, css);
            m_full = 0;
          end else begin
            m_cur = '0; m_col = '0; m_under = 1;
          end
        end
        m_pix = m_cur[CW-1-m_pos];
        m_pos = (m_pos + 1) % CW;
      end else if (pixel_en) begin
        m_pix = 0; m_col = '0; m_pos = 0;
      end
      if (take) begin
        m_full = 1; m_byte = data_in;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; frame_start = 0; line_start = 0; pixel_en = 0; data_valid = 0;
  endtask

  task automatic pulse_frame();
    idle(); frame_start = 1; step(); frame_start = 0;
  endtask

  task automatic pulse_line();
    idle(); line_start = 1; step(); line_start = 0;
  endtask

  task automatic load_byte(input logic [7:0] b);
    idle(); data_valid = 1; data_in = b; step(); data_valid = 0;
  endtask

  task automatic run_char(output logic [CW-1:0] pix, output int uf);
    uf = 0;
    for (int i = 0; i < CW; i++) begin
      pixel_en = 1; display_en = 1;
      step();
      pix[CW-1-i] = pixel_out;
      if (underflow === 1'b1) uf++;
    end
    pixel_en = 0;
  endtask

  task automatic test_reset();
    idle(); reset = 1; step(); step(); reset = 0;
    n_checks++;
    if (pixel_out !== 1'b0 || colour_out !== '0 || underflow !== 1'b0 ||
        data_ready !== 1'b1 || row_out !== '0) begin
      n_errors++;
      $display("FAIL reset: pix=%b col=%0d uf=%b rdy=%b row=%0d required 0 0 0 1 0",
               pixel_out, colour_out, underflow, data_ready, row_out);
    end
  endtask

  task automatic test_sg4();
    logic [CW-1:0] pix;
    int uf;
    mode = 2'b00; css = 0;
    pulse_frame();
    load_byte(8'h21);
    run_char(pix, uf);
    n_checks++;
    if (pix !== 8'hF0 || colour_out !== 4'd3) begin
      n_errors++;
      $display("FAIL sg4_row0: pix=%b col=%0d required 11110000 col 3", pix, colour_out);
    end
    for (int i = 0; i < 6; i++) pulse_line();
    n_checks++;
    if (row_out !== ROW_W'(6)) begin
      n_errors++;
      $display("FAIL sg4_row_count: row=%0d required 6", row_out);
    end
    load_byte(8'h21);
    run_char(pix, uf);
    n_checks++;
    if (pix !== 8'h00 || colour_out !== 4'd3) begin
      n_errors++;
      $display("FAIL sg4_row6: pix=%b col=%0d required 00000000 col 3", pix, colour_out);
    end
  endtask

  task automatic test_sg6();
    logic [CW-1:0] pix;
    logic [CW-1:0] want;
    int uf;
    mode = 2'b01; css = 1;
    pulse_frame();
    for (int r = 0; r < R; r++) begin
      load_byte(8'hD0);
      run_char(pix, uf);
      want = (r >= 8) ? 8'hF0 : 8'h00;
      n_checks++;
      if (pix !== want || colour_out !== 4'd8) begin
        n_errors++;
        $display("FAIL sg6_row%0d: pix=%b col=%0d required %b col 8", r, pix, colour_out, want);
      end
      pulse_line();
    end
  endtask

  task automatic test_underflow();
    logic [CW-1:0] pix;
    int uf;
    mode = 2'b00; css = 0;
    run_char(pix, uf);
    n_checks++;
    if (pix !== 8'h00 || uf != 1 || colour_out !== '0) begin
      n_errors++;
      $display("FAIL underflow: pix=%b pulses=%0d col=%0d required 00000000 1 0", pix, uf, colour_out);
    end
  endtask

  task automatic test_row_wrap();
    logic [CW-1:0] pix;
    int uf;
    mode = 2'b00;
    pulse_frame();
    for (int i = 0; i < R - 1; i++) pulse_line();
    n_checks++;
    if (row_out !== ROW_W'(R - 1)) begin
      n_errors++;
      $display("FAIL row_last: row=%0d required %0d", row_out, R - 1);
    end
    pulse_line();
    n_checks++;
    if (row_out !== '0) begin
      n_errors++;
      $display("FAIL row_wrap: row=%0d required 0", row_out);
    end
    load_byte(8'hFF);
    idle(); line_start = 1; pixel_en = 1; display_en = 1; step();
    n_checks++;
    if (pixel_out !== 1'b0 || data_ready !== 1'b0 || row_out !== ROW_W'(1)) begin
      n_errors++;
      $display("FAIL line_and_pixel: pix=%b rdy=%b row=%0d required 0 0 1", pixel_out, data_ready, row_out);
    end
    idle(); pixel_en = 1; step();
    n_checks++;
    if (pixel_out !== 1'b1 || data_ready !== 1'b1 || colour_out !== 4'd8) begin
      n_errors++;
      $display("FAIL after_line_pixel: pix=%b rdy=%b col=%0d required 1 1 8", pixel_out, data_ready, colour_out);
    end
    for (int i = 1; i < CW; i++) step();
    pixel_en = 0;
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] pix;
    int uf;
    mode = 2'b00;
    idle(); data_valid = 1; data_in = 8'h12; step();
    data_in = 8'h31;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (data_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_stall%0d: rdy=%b required 0", i, data_ready);
      end
    end
    pixel_en = 1; display_en = 1; step();
    n_checks++;
    if (data_ready !== 1'b1 || pixel_out !== 1'b0 || colour_out !== 4'd2) begin
      n_errors++;
      $display("FAIL bp_consume: rdy=%b pix=%b col=%0d required 1 0 2", data_ready, pixel_out, colour_out);
    end
    step();
    n_checks++;
    if (data_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_reload: rdy=%b required 0", data_ready);
    end
    data_valid = 0;
    for (int i = 2; i < CW; i++) step();
    run_char(pix, uf);
    n_checks++;
    if (pix !== 8'hF0 || colour_out !== 4'd4 || uf != 0) begin
      n_errors++;
      $display("FAIL bp_second: pix=%b col=%0d uf=%0d required 11110000 4 0", pix, colour_out, uf);
    end
  endtask

  task automatic test_reset_mid();
    mode = 2'b00;
    pulse_line(); pulse_line();
    load_byte(8'hFF);
    idle(); pixel_en = 1; display_en = 1;
    for (int i = 0; i < 3; i++) step();
    load_byte(8'h55);
    idle(); reset = 1; pixel_en = 1; step(); reset = 0;
    n_checks++;
    if (pixel_out !== 1'b0 || colour_out !== '0 || data_ready !== 1'b1 ||
        row_out !== '0 || underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid: pix=%b col=%0d rdy=%b row=%0d uf=%b required 0 0 1 0 0",
               pixel_out, colour_out, data_ready, row_out, underflow);
    end
    step();
    n_checks++;
    if (underflow !== 1'b1 || pixel_out !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_discard: uf=%b pix=%b required 1 0", underflow, pixel_out);
    end
    pixel_en = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      reset       = ($urandom_range(0, 499) == 0);
      frame_start = ($urandom_range(0, 199) == 0);
      line_start  = ($urandom_range(0, 23) == 0);
      pixel_en    = ($urandom_range(0, 1) == 1);
      display_en  = ($urandom_range(0, 7) != 0);
      data_valid  = ($urandom_range(0, 2) == 0);
      data_in     = 8'($urandom);
      if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
      css = ($urandom_range(0, 1) == 1);
      step();
      n_checks++;
      if (pixel_out !== m_pix || colour_out !== m_col || data_ready !== !m_full ||
          row_out !== ROW_W'(m_row) || underflow !== m_under) begin
        n_errors++;
        $display("FAIL random_c%0d: pix=%b col=%0d rdy=%b row=%0d uf=%b required %b %0d %b %0d %b",
                 c, pixel_out, colour_out, data_ready, row_out, underflow,
                 m_pix, m_col, !m_full, m_row, m_under);
      end
    end
    idle();
  endtask

  initial begin
    reset = 1; css = 0; display_en = 0; frame_start = 0; line_start = 0;
    pixel_en = 0; data_valid = 0; mode = 2'b00; data_in = '0;
    test_reset();
    test_sg4();
    test_sg6();
    test_underflow();
    test_row_wrap();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
